// File: rtl/div_iter_unit.sv
`default_nettype none
// ============================================================================
// Module   : div_iter_unit
// Purpose  : Multi-cycle RV64M divider (DIV/DIVU/REM/REMU and W forms) using a
//            restoring shift-subtract loop; negations go through the shared adder.
// Revision : 1.0  initial release
// ============================================================================
module div_iter_unit #(
  parameter int WIDTH = 64,
  parameter int CNT_W = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             div_valid,
  output logic             div_ready,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic             div_signed,
  input  logic             div_w,
  input  logic             rem_sel,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             add_req,
  output logic             adder_AorS,
  output logic [WIDTH-1:0] adder_src0,
  output logic [WIDTH-1:0] adder_src1,
  output logic             adder_src0_vld,
  output logic             adder_src1_vld,
  output logic             adder_w_inst,
  input  logic [WIDTH-1:0] adder_sum
);

  localparam int HW = WIDTH / 2;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ABS_A = 3'd1;
  localparam logic [2:0] S_ABS_B = 3'd2;
  localparam logic [2:0] S_ITER  = 3'd3;
  localparam logic [2:0] S_FIX   = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  logic [2:0]       r_state, w_next;
  logic [WIDTH-1:0] r_quo, r_rem, r_b, r_result;
  logic [CNT_W-1:0] r_cnt;
  logic             r_a_neg, r_b_neg, r_w, r_rem_sel;

  logic [WIDTH-1:0] w_ext_a, w_ext_b, w_fast_res, w_abs_a, w_raw, w_fixed;
  logic [WIDTH:0]   w_rem_sh, w_trial;
  logic             w_div_zero, w_ovf, w_fast, w_borrow, w_neg_res;

  // Operand extension for W forms happens once, at accept.
  assign w_ext_a = div_w ? {{HW{div_signed & dividend[HW-1]}}, dividend[HW-1:0]} : dividend;
  assign w_ext_b = div_w ? {{HW{div_signed & divisor[HW-1]}},  divisor[HW-1:0]}  : divisor;

  assign w_div_zero = (w_ext_b == '0);
  assign w_ovf      = div_signed && (&w_ext_b) &&
                      (div_w ? (w_ext_a[HW-1:0] == {1'b1, {(HW-1){1'b0}}})
                             : (w_ext_a == {1'b1, {(WIDTH-1){1'b0}}}));
  assign w_fast     = w_div_zero || w_ovf;
  assign w_fast_res = w_div_zero ? (rem_sel ? w_ext_a : '1)
                                 : (rem_sel ? '0 : w_ext_a);

  assign w_abs_a = r_a_neg ? adder_sum : r_quo;

  // Remainder stays below the divisor, so bit WIDTH of the trial is the borrow.
  assign w_rem_sh = {r_rem, r_quo[WIDTH-1]};
  assign w_trial  = w_rem_sh - {1'b0, r_b};
  assign w_borrow = w_trial[WIDTH];

  assign w_raw     = r_rem_sel ? r_rem : r_quo;
  assign w_neg_res = r_rem_sel ? r_a_neg : (r_a_neg ^ r_b_neg);
  assign w_fixed   = w_neg_res ? adder_sum : w_raw;

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (div_valid) w_next = w_fast ? S_DONE : S_ABS_A;
      S_ABS_A: w_next = S_ABS_B;
      S_ABS_B: w_next = S_ITER;
      S_ITER:  if (r_cnt == CNT_W'(1)) w_next = S_FIX;
      S_FIX:   w_next = S_DONE;
      S_DONE:  if (out_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
    if (flush) w_next = S_IDLE;
  end

  always_comb begin
    div_ready      = (r_state == S_IDLE);
    out_valid      = (r_state == S_DONE);
    result         = r_result;
    add_req        = 1'b0;
    adder_AorS     = 1'b0;
    adder_src0     = '0;
    adder_src1     = '0;
    adder_src0_vld = 1'b0;
    adder_src1_vld = 1'b0;
    adder_w_inst   = 1'b0;
    if (r_state == S_ABS_A || r_state == S_ABS_B || r_state == S_FIX) begin
      add_req        = 1'b1;
      adder_AorS     = 1'b1;
      adder_src0_vld = 1'b1;
      adder_src1_vld = 1'b1;
      case (r_state)
        S_ABS_A: adder_src1 = r_quo;
        S_ABS_B: adder_src1 = r_b;
        default: adder_src1 = w_raw;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_quo     <= '0;
      r_rem     <= '0;
      r_b       <= '0;
      r_result  <= '0;
      r_cnt     <= '0;
      r_a_neg   <= 1'b0;
      r_b_neg   <= 1'b0;
      r_w       <= 1'b0;
      r_rem_sel <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (div_valid && !flush) begin
          r_quo     <= w_ext_a;
          r_b       <= w_ext_b;
          r_rem     <= '0;
          r_a_neg   <= div_signed & w_ext_a[WIDTH-1];
          r_b_neg   <= div_signed & w_ext_b[WIDTH-1];
          r_w       <= div_w;
          r_rem_sel <= rem_sel;
          if (w_fast) r_result <= w_fast_res;
        end
        S_ABS_A: r_quo <= r_w ? {w_abs_a[HW-1:0], {HW{1'b0}}} : w_abs_a;
        S_ABS_B: begin
          if (r_b_neg) r_b <= adder_sum;
          r_cnt <= r_w ? CNT_W'(HW) : CNT_W'(WIDTH);
        end
        S_ITER: begin
          r_rem <= w_borrow ? w_rem_sh[WIDTH-1:0] : w_trial[WIDTH-1:0];
          r_quo <= {r_quo[WIDTH-2:0], ~w_borrow};
          r_cnt <= r_cnt - CNT_W'(1);
        end
        S_FIX: if (!flush)
          r_result <= r_w ? {{HW{w_fixed[HW-1]}}, w_fixed[HW-1:0]} : w_fixed;
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_div_iter_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_div_iter_unit
// Purpose  : Directed self-checking bench for div_iter_unit.
// Revision : 1.0  initial release
// ============================================================================
module tb_div_iter_unit;

  logic        clk = 1'b0;
  logic        rst, div_valid, div_ready, div_signed, div_w, rem_sel, flush;
  logic        out_valid, out_ready, add_req, adder_AorS;
  logic        adder_src0_vld, adder_src1_vld, adder_w_inst;
  logic [63:0] dividend, divisor, result, adder_src0, adder_src1, adder_sum;

  int vectors = 0;
  int miscompares = 0;
  int g_req_pos[$];
  int g_adder_bad = 0;

  always #5 clk = ~clk;

  // Shared ALU adder, combinational.
  assign adder_sum = adder_AorS ? (adder_src0 - adder_src1) : (adder_src0 + adder_src1);

  div_iter_unit #(.WIDTH(64), .CNT_W(7)) dut (
    .clk(clk), .rst(rst), .div_valid(div_valid), .div_ready(div_ready),
    .dividend(dividend), .divisor(divisor), .div_signed(div_signed),
    .div_w(div_w), .rem_sel(rem_sel), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .result(result), .add_req(add_req),
    .adder_AorS(adder_AorS), .adder_src0(adder_src0), .adder_src1(adder_src1),
    .adder_src0_vld(adder_src0_vld), .adder_src1_vld(adder_src1_vld),
    .adder_w_inst(adder_w_inst), .adder_sum(adder_sum)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic audit_adder();
    if (add_req) begin
      if (!adder_AorS || adder_src0 != 64'd0 || !adder_src0_vld || !adder_src1_vld || adder_w_inst)
        g_adder_bad++;
    end else if (adder_AorS || adder_src0 != 64'd0 || adder_src1 != 64'd0 ||
                 adder_src0_vld || adder_src1_vld || adder_w_inst) begin
      g_adder_bad++;
    end
  endtask

  // Returns at the negedge right after the accepting posedge.
  task automatic issue(input logic [63:0] a, input logic [63:0] b,
                       input logic s, input logic w, input logic r);
    @(negedge clk);
    dividend = a; divisor = b; div_signed = s; div_w = w; rem_sel = r;
    div_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    div_valid = 1'b0;
  endtask

  task automatic run_op(input logic [63:0] a, input logic [63:0] b,
                        input logic s, input logic w, input logic r,
                        input logic [63:0] exp, input int exp_lat,
                        input int hold, input string tag);
    int n;
    int bad;
    logic [63:0] held;
    g_req_pos.delete();
    issue(a, b, s, w, r);
    n = 0;
    while (!out_valid && n < 200) begin
      if (add_req) g_req_pos.push_back(n);
      audit_adder();
      @(negedge clk);
      n++;
    end
    chk({tag, "_latency"}, 64'(n), 64'(exp_lat));
    chk({tag, "_result"}, result, exp);
    bad = 0;
    held = result;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      if (result !== held || div_ready !== 1'b0 || out_valid !== 1'b1) bad++;
    end
    if (hold > 0) chk({tag, "_hold"}, 64'(bad), 64'd0);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk({tag, "_handshake"}, {62'd0, div_ready, out_valid}, 64'b10);
  endtask

  initial begin
    int seen;
    rst = 1'b1; div_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
    dividend = '0; divisor = '0; div_signed = 1'b0; div_w = 1'b0; rem_sel = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_ctl", {60'd0, div_ready, out_valid, add_req, adder_AorS}, 64'b1000);
    chk("reset_result", result, 64'd0);
    chk("reset_src1", adder_src1, 64'd0);
    rst = 1'b0;

    run_op(64'd100, 64'd7, 1'b0, 1'b0, 1'b0, 64'd14, 67, 0, "divu_100_7");
    run_op(64'd100, 64'd7, 1'b0, 1'b0, 1'b1, 64'd2,  67, 0, "remu_100_7");

    run_op(64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 1'b1, 1'b0, 1'b0,
           64'hFFFF_FFFF_FFFF_FFFD, 67, 0, "div_m7_2");
    chk("div_addreq_pulses",
        {61'd0, g_req_pos.size() == 3,
         g_req_pos.size() == 3 && g_req_pos[0] == 0 && g_req_pos[1] == 1,
         g_req_pos.size() == 3 && g_req_pos[2] == 66}, 64'b111);
    run_op(64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 1'b1, 1'b0, 1'b1,
           64'hFFFF_FFFF_FFFF_FFFF, 67, 0, "rem_m7_2");

    run_op(64'd5, 64'd0, 1'b0, 1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 0, 0, "divu_by0");
    run_op(64'h0000_0001_8000_0000, 64'd0, 1'b1, 1'b1, 1'b1,
           64'hFFFF_FFFF_8000_0000, 0, 0, "remw_by0");

    run_op(64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 1'b0,
           64'h8000_0000_0000_0000, 0, 0, "div_ovf");
    run_op(64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 1'b1,
           64'd0, 0, 0, "rem_ovf");
    run_op(64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, 1'b1, 1'b1, 1'b0,
           64'hFFFF_FFFF_8000_0000, 0, 0, "divw_ovf");

    run_op(64'hFFFF_FFFF_FFFF_FFFE, 64'd2, 1'b0, 1'b1, 1'b0,
           64'h0000_0000_7FFF_FFFF, 35, 10, "divuw_hold");
    run_op(64'h1234_5678_FFFF_FFF9, 64'd2, 1'b1, 1'b1, 1'b0,
           64'hFFFF_FFFF_FFFF_FFFD, 35, 0, "divw_m7_2");
    run_op(64'h0000_0000_FFFF_FFF9, 64'h0000_0000_FFFF_FFFE, 1'b1, 1'b1, 1'b1,
           64'hFFFF_FFFF_FFFF_FFFF, 35, 0, "remw_m7_m2");
    chk("adder_iface", 64'(g_adder_bad), 64'd0);

    // Flush in the middle of the iteration loop.
    issue(64'd1000, 64'd3, 1'b0, 1'b0, 1'b0);
    repeat (21) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flush_iter_idle", {61'd0, div_ready, out_valid, add_req}, 64'b100);
    seen = 0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    chk("flush_no_valid", 64'(seen), 64'd0);
    run_op(64'd9, 64'd3, 1'b0, 1'b0, 1'b0, 64'd3, 67, 0, "divu_9_3");

    // Flush beats a same-cycle request.
    @(negedge clk);
    dividend = 64'd50; divisor = 64'd5; div_signed = 1'b0; div_w = 1'b0; rem_sel = 1'b0;
    div_valid = 1'b1; flush = 1'b1;
    @(negedge clk);
    div_valid = 1'b0; flush = 1'b0;
    chk("flush_over_accept", {61'd0, div_ready, out_valid, add_req}, 64'b100);

    // Flush beats the result handshake in DONE.
    issue(64'd5, 64'd0, 1'b0, 1'b0, 1'b0);
    chk("fast_done_valid", {63'd0, out_valid}, 64'd1);
    flush = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    flush = 1'b0; out_ready = 1'b0;
    chk("flush_in_done", {62'd0, div_ready, out_valid}, 64'b10);

    // Reset in the middle of the iteration loop.
    issue(64'd1000, 64'd7, 1'b0, 1'b0, 1'b0);
    repeat (30) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_iter_ctl", {60'd0, div_ready, out_valid, add_req, adder_src1_vld}, 64'b1000);
    chk("rst_iter_result", result, 64'd0);
    rst = 1'b0;
    run_op(64'd1000, 64'd7, 1'b0, 1'b0, 1'b1, 64'd6, 67, 0, "remu_after_rst");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
